// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: ALU command encoding,
// stage FSM states, and a helper that identifies arithmetic commands.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } stage_state_e;

    // Carry and overflow only carry meaning for ADD and SUB.
    function automatic logic isArith(input logic [2:0] cmd);
        return (cmd == ALU_ADD) || (cmd == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// 32-bit ALU. A single adder serves ADD directly and computes A-B for every
// other command, so SLT reuses the subtractor and the raw carry/overflow
// outputs reflect A-B for the non-arithmetic commands.
module alu
    import alu_pkg::*;
(
    output logic [31:0] result,
    output logic        carryout,
    output logic        zero,
    output logic        overflow,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [2:0]  command
);

    logic        isAdd;
    logic [31:0] bOperand;
    logic [32:0] sum;
    logic        sumOvf;
    logic        lessThan;

    // Shared add/subtract path, signed-less-than from the subtractor, and the
    // command-selected result with its flags.
    always_comb begin
        isAdd    = (command == ALU_ADD);
        bOperand = isAdd ? operandB : ~operandB;
        sum      = {1'b0, operandA} + {1'b0, bOperand} + {32'd0, ~isAdd};
        sumOvf   = (operandA[31] == bOperand[31]) && (sum[31] != operandA[31]);
        lessThan = sum[31] ^ sumOvf;
        result   = '0;
        case (command)
            ALU_ADD,
            ALU_SUB:  result = sum[31:0];
            ALU_XOR:  result = operandA ^ operandB;
            ALU_SLT:  result = {31'd0, lessThan};
            ALU_AND:  result = operandA & operandB;
            ALU_NAND: result = ~(operandA & operandB);
            ALU_NOR:  result = ~(operandA | operandB);
            ALU_OR:   result = operandA | operandB;
            default:  result = '0;
        endcase
        carryout = sum[32];
        overflow = sumOvf;
        zero     = (result == '0);
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage around the ALU: accepts one op per handshake, holds the
// operands for SETTLE_CYCLES clocks, captures the ALU outputs and presents
// them downstream. Keeps a sticky overflow flag and a handshake counter.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      operandA,
    input  logic [31:0]      operandB,
    input  logic [2:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    stage_state_e     state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [31:0]      opA_q,      opA_d;
    logic [31:0]      opB_q,      opB_d;
    logic [2:0]       cmd_q,      cmd_d;
    logic [31:0]      result_q,   result_d;
    logic             carry_q,    carry_d;
    logic             zero_q,     zero_d;
    logic             ovf_q,      ovf_d;
    logic             outValid_q, outValid_d;
    logic             sticky_q,   sticky_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic [31:0] aluResult;
    logic        aluCarry;
    logic        aluZero;
    logic        aluOvf;
    logic        accept;
    logic        outHs;

    alu u_alu (
        .result   (aluResult),
        .carryout (aluCarry),
        .zero     (aluZero),
        .overflow (aluOvf),
        .operandA (opA_q),
        .operandB (opB_q),
        .command  (cmd_q)
    );

    // Ready is suppressed during reset; in DONE a new op may enter only on the
    // same edge the current result leaves.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
        accept = in_valid && in_ready;
        outHs  = outValid_q && out_ready;
    end

    // Next-state logic: operand latch on accept, settle countdown, capture of
    // the ALU outputs with carry/overflow masked, plus sticky flag and counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        cmd_d      = cmd_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        sticky_d   = sticky_q;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opA_d   = operandA;
                    opB_d   = operandB;
                    cmd_d   = command;
                    cnt_d   = CNT_INIT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    result_d   = aluResult;
                    carry_d    = aluCarry & isArith(cmd_q);
                    zero_d     = aluZero;
                    ovf_d      = aluOvf & isArith(cmd_q);
                    outValid_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    if (accept) begin
                        opA_d   = operandA;
                        opB_d   = operandB;
                        cmd_d   = command;
                        cnt_d   = CNT_INIT;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (outHs && ovf_q) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end

        if (outHs) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State register; reset discards any in-flight op and clears all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            cmd_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            cmd_q      <= cmd_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign out_valid  = outValid_q;
    assign result     = result_q;
    assign carryout   = carry_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;
    assign sticky_ovf = sticky_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: hand-written vectors, stall / same-edge /
// reset / sticky corner sequences, and random ops against a reference model.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int SETTLE = 4;
    localparam int CW     = 8;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   operandA;
    logic [31:0]   operandB;
    logic [2:0]    command;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;
    logic          carryout;
    logic          zero;
    logic          overflow;
    logic          sticky_ovf;
    logic          clr_sticky;
    logic [CW-1:0] op_count;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] expCount;
    logic          expSticky;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[12];

    alu_exec_stage #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operandA   (operandA),
        .operandB   (operandB),
        .command    (command),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carryout   (carryout),
        .zero       (zero),
        .overflow   (overflow),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Reference ALU computed from wide signed/unsigned arithmetic.
    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        exp_t   r;
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r.c = 1'b0;
        r.v = 1'b0;
        case (cmd)
            ALU_ADD: begin
                full  = sa + sb;
                r.res = 32'(ua + ub);
                r.c   = (ua + ub) > 64'sh00000000FFFFFFFF;
                r.v   = (full > MAXS) || (full < MINS);
            end
            ALU_SUB: begin
                full  = sa - sb;
                r.res = 32'(ua - ub);
                r.c   = (ua >= ub);
                r.v   = (full > MAXS) || (full < MINS);
            end
            ALU_XOR:  r.res = a ^ b;
            ALU_SLT:  r.res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_AND:  r.res = a & b;
            ALU_NAND: r.res = ~(a & b);
            ALU_NOR:  r.res = ~(a | b);
            default:  r.res = a | b;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic acceptOp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        int waited;
        operandA = a;
        operandB = b;
        command  = cmd;
        in_valid = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 100);
        if (!in_ready) checkOutput("acceptTimeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitCapture(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd, output int lat);
        acceptOp(a, b, cmd);
        waitCapture(lat);
    endtask

    task automatic expectResult(input string tag, input exp_t e, input int lat);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(SETTLE));
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, ".result"}, result, e.res);
        checkOutput({tag, ".carryout"}, {31'd0, carryout}, {31'd0, e.c});
        checkOutput({tag, ".zero"}, {31'd0, zero}, {31'd0, e.z});
        checkOutput({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e.v});
        checkOutput({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic takeResult(input string tag, input logic v, input logic clr);
        out_ready  = 1'b1;
        clr_sticky = clr;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        expCount   = expCount + 1'b1;
        if (v) expSticky = 1'b1;
        else if (clr) expSticky = 1'b0;
        checkOutput({tag, ".dropValid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, ".op_count"}, {24'd0, op_count}, {24'd0, expCount});
        checkOutput({tag, ".sticky"}, {31'd0, sticky_ovf}, {31'd0, expSticky});
    endtask

    task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd, input exp_t e);
        int lat;
        applyStimulus(a, b, cmd, lat);
        expectResult(tag, e, lat);
        takeResult(tag, e.v, 1'b0);
    endtask

    // Main test sequence.
    initial begin
        exp_t        e;
        int          lat;
        int          iter;
        logic        sawValid;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rc;

        vecs[0]  = '{"add",      32'h00030D40, 32'h00004E20, ALU_ADD,  32'h00035B60, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"subOvf",   32'h0BEBC200, 32'h88CA6C00, ALU_SUB,  32'h83215600, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{"subPos",   32'h00030D40, 32'h00004E20, ALU_SUB,  32'h0002BF20, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"subZero",  32'h000186A0, 32'h000186A0, ALU_SUB,  32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{"xor",      32'd3,        32'd5,        ALU_XOR,  32'h00000006, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"slt",      32'd3,        32'd5,        ALU_SLT,  32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"and",      32'd3,        32'd5,        ALU_AND,  32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"nand",     32'd3,        32'd5,        ALU_NAND, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"or",       32'd3,        32'd5,        ALU_OR,   32'h00000007, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"addWrap",  32'hFFFFFFFF, 32'h00000001, ALU_ADD,  32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"addOvf",   32'h7FFFFFFF, 32'h00000001, ALU_ADD,  32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"sltNeg",   32'hFFFFFFFF, 32'h00000001, ALU_SLT,  32'h00000001, 1'b0, 1'b0, 1'b0};

        reset      = 1'b1;
        in_valid   = 1'b0;
        operandA   = '0;
        operandB   = '0;
        command    = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        expCount   = '0;
        expSticky  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst.result", result, 32'd0);
        checkOutput("rst.op_count", {24'd0, op_count}, 32'd0);
        checkOutput("rst.sticky", {31'd0, sticky_ovf}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("idle.in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            e = '{vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v};
            doOp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cmd, e);
        end

        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        expSticky  = 1'b0;
        checkOutput("clrPulse.sticky", {31'd0, sticky_ovf}, 32'd0);

        applyStimulus(32'h7FFFFFFF, 32'h00000001, ALU_ADD, lat);
        e = refModel(32'h7FFFFFFF, 32'h00000001, ALU_ADD);
        expectResult("stallCap", e, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall.out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall.result", result, 32'h80000000);
            checkOutput("stall.overflow", {31'd0, overflow}, 32'd1);
            checkOutput("stall.in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall.op_count", {24'd0, op_count}, {24'd0, expCount});
        end
        operandA  = 32'd3;
        operandB  = 32'd5;
        command   = ALU_NOR;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("sameEdge.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expCount  = expCount + 1'b1;
        expSticky = 1'b1;
        checkOutput("sameEdge.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("sameEdge.op_count", {24'd0, op_count}, {24'd0, expCount});
        checkOutput("sameEdge.sticky", {31'd0, sticky_ovf}, 32'd1);
        waitCapture(lat);
        expectResult("nor", '{32'hFFFFFFF8, 1'b0, 1'b0, 1'b0}, lat);
        takeResult("nor", 1'b0, 1'b0);

        acceptOp(32'd3, 32'd5, ALU_AND);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRst.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        expCount  = '0;
        expSticky = 1'b0;
        checkOutput("midRst.out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midRst.result", result, 32'd0);
        checkOutput("midRst.flags", {29'd0, carryout, zero, overflow}, 32'd0);
        checkOutput("midRst.sticky", {31'd0, sticky_ovf}, 32'd0);
        checkOutput("midRst.op_count", {24'd0, op_count}, 32'd0);
        sawValid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midRst.noValid", {31'd0, sawValid}, 32'd0);
        doOp("orAfterRst", 32'd3, 32'd5, ALU_OR, '{32'h00000007, 1'b0, 1'b0, 1'b0});

        applyStimulus(32'h0BEBC200, 32'h88CA6C00, ALU_SUB, lat);
        e = refModel(32'h0BEBC200, 32'h88CA6C00, ALU_SUB);
        expectResult("setVsClr", e, lat);
        takeResult("setVsClr", e.v, 1'b1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        expSticky  = 1'b0;
        checkOutput("clrAfter.sticky", {31'd0, sticky_ovf}, 32'd0);

        iter = 0;
        do begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
            rc = 3'($urandom_range(0, 7));
            e  = refModel(ra, rb, rc);
            doOp("rand", ra, rb, rc, e);
            iter++;
        end while (expCount != '0 && iter < 300);
        checkOutput("wrap.op_count", {24'd0, op_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit");
    end

endmodule
